block_mem_responder: RTL
========================

Name: block_mem_responder

Overview:
- Main-memory target for the nand_cpu cache miss/writeback path. Answers one cache-block read or write request at a time over a valid/ready request channel and a valid/ready response channel.
- Response latency is fixed and programmable.
- Storage is one array named core, indexed by block address, one entry per cache block. Benches may load or inspect it hierarchically (DUT.MEMORY.core[i]).
- Sits between the cache controller (initiator) and nothing else; it is the memory end of the block-transfer protocol.

Parameters:
- ADDR_WIDTH, 16, block-address width; core holds 2**ADDR_WIDTH entries.
- BLOCK_BITS, 64, bits per block; equals `CACHE_BLOCK_SIZE.
- LATENCY, 4, cycles from request acceptance to resp_valid; legal range 1..255.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = write block, 0 = read block.
- req_addr  input  ADDR_WIDTH  block address.
- req_wdata  input  BLOCK_BITS  write data.
- resp_valid  output  1  response available.
- resp_ready  input  1  initiator takes the response.
- resp_rdata  output  BLOCK_BITS  read data; echoes write data on write acks.
- resp_write  output  1  response is the ack of a write.
- rd_count  output  16  completed reads, saturating.
- wr_count  output  16  completed writes, saturating.

Behaviour:
- Reset (rst high at an edge):
  - State goes to IDLE.
  - req_ready=0 during the reset cycle, then 1 in the first cycle after rst falls.
  - resp_valid=0, resp_rdata=0, resp_write=0, rd_count=0, wr_count=0.
  - core is NOT reset; contents persist across reset.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch addr/write/wdata and load cnt=LATENCY-1. Go to RESPOND directly if LATENCY==1, else WAIT.
  - WAIT: req_ready=0. Decrement cnt each cycle. When cnt==1 at an edge, perform the access and go to RESPOND.
  - RESPOND: resp_valid=1 and req_ready=0. On resp_valid&&resp_ready go to IDLE.
- Access happens on the edge entering RESPOND:
  - Read: resp_rdata <= core[addr].
  - Write: core[addr] <= wdata and resp_rdata <= wdata.
  - resp_write <= latched write flag.
- Timing: request accepted at edge N gives resp_valid=1 in the cycle after edge N+LATENCY-1. That is LATENCY cycles of visible latency, counting the acceptance cycle.
- Response is held stable (valid, rdata, write) until the handshake. Back-pressure of any length is legal.
- No overlap:
  - req_ready returns to 1 only in the cycle after the response handshake.
  - A request presented while busy is neither accepted nor dropped; the initiator keeps it asserted.
- Request inputs are ignored outside the IDLE acceptance edge. Changes to req_* while in WAIT or RESPOND have no effect.
- Counters: +1 at each response handshake (rd_count for reads, wr_count for writes). Each saturates at 16'hFFFF.
- Reset mid-operation:
  - A write still in WAIT is not committed; core is unchanged.
  - A write already in RESPOND has been committed.
  - Any pending response is discarded.
- Read-after-write to the same address on back-to-back transactions returns the new data.

Test Plan:
- Reset, then read addr 0x0010 preloaded with 64'h0123_4567_89AB_CDEF, resp_ready=1 -> resp_valid rises 4 cycles after acceptance, rdata=64'h0123_4567_89AB_CDEF, resp_write=0, rd_count=1.
- Write addr 0x0020 data 64'hDEAD_BEEF_0000_FFFF, then read 0x0020 -> write ack has resp_write=1 and rdata echo; the read returns 64'hDEAD_BEEF_0000_FFFF; wr_count=1, rd_count=1.
- Read with resp_ready held low 10 cycles -> resp_valid and rdata stable all 10 cycles; req_ready=0 throughout; a second req_valid is not accepted until the cycle after the handshake.
- Write to 0x0030 (old value 64'h1111) with rst asserted 2 cycles after acceptance (LATENCY=4) -> core[0x30] stays 64'h1111; resp_valid=0; counters 0; req_ready=1 the cycle after rst falls.
- LATENCY=1 build: read accepted at edge N -> resp_valid=1 in the cycle after edge N; 100 random back-to-back read/writes match a bench shadow model.
- Force 65536 reads (or preload counter via hierarchy to 16'hFFFE) -> rd_count goes FFFE, FFFF, then stays at FFFF.

Source files
------------

// File: rtl/block_mem_responder.sv
// Block-granular memory target for cache fills and writebacks.
// Serves one request at a time; each response appears a fixed, programmable number of cycles after acceptance.
module block_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned BLOCK_BITS = 64,
  parameter int unsigned LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [BLOCK_BITS-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [BLOCK_BITS-1:0] resp_rdata,
  output logic                  resp_write,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
);

  localparam int unsigned DEPTH    = 32'(1) << ADDR_WIDTH;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned CNT_BITS = 16;
  localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESPOND} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [BLOCK_BITS-1:0] wdata_q, wdata_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [BLOCK_BITS-1:0] resp_rdata_q, resp_rdata_d;
  logic                  resp_write_q, resp_write_d;
  logic [CNT_BITS-1:0]   rd_count_q, rd_count_d;
  logic [CNT_BITS-1:0]   wr_count_q, wr_count_d;

  logic                  accept;
  logic                  wait_done;
  logic                  do_access;
  logic                  hs;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic                  acc_write;
  logic [BLOCK_BITS-1:0] acc_wdata;
  logic                  mem_we;
  logic [BLOCK_BITS-1:0] rd_word;

  assign accept    = req_valid && req_ready_q;
  assign wait_done = (state_q == S_WAIT) && (cnt_q == CNT_W'(1));
  assign hs        = resp_valid_q && resp_ready;

  // Single-cycle latency accesses straight off the request; otherwise from the latched copy.
  assign do_access = (accept && (LATENCY == 1)) || wait_done;
  assign acc_addr  = wait_done ? addr_q  : req_addr;
  assign acc_write = wait_done ? write_q : req_write;
  assign acc_wdata = wait_done ? wdata_q : req_wdata;
  assign mem_we    = do_access && acc_write;

  // Backing store; deliberately not reset so contents survive rst.
  if (1) begin : MEMORY
    logic [BLOCK_BITS-1:0] core [DEPTH];

    always_ff @(posedge clk) begin
      if (!rst && mem_we) core[acc_addr] <= acc_wdata;
    end

    assign rd_word = core[acc_addr];
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_write_d = resp_write_q;
    rd_count_d   = rd_count_q;
    wr_count_d   = wr_count_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = req_addr;
          write_d = req_write;
          wdata_d = req_wdata;
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY == 1) ? S_RESPOND : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_RESPOND;
      end
      S_RESPOND: begin
        if (hs) begin
          state_d = S_IDLE;
          if (write_q) begin
            if (wr_count_q != CNT_MAX) wr_count_d = wr_count_q + CNT_BITS'(1);
          end else begin
            if (rd_count_q != CNT_MAX) rd_count_d = rd_count_q + CNT_BITS'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (do_access) begin
      resp_rdata_d = acc_write ? acc_wdata : rd_word;
      resp_write_d = acc_write;
    end

    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESPOND);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_write_q <= 1'b0;
      rd_count_q   <= '0;
      wr_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_write_q <= resp_write_d;
      rd_count_q   <= rd_count_d;
      wr_count_q   <= wr_count_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_write = resp_write_q;
  assign rd_count   = rd_count_q;
  assign wr_count   = wr_count_q;

endmodule
